// File: rtl/fpio_mchan_pkg.sv
// Shared register map, IRQ cause bit positions and STATUS layout for fpio_mchan.
package fpio_mchan_pkg;
  typedef enum logic [2:0] {
    OFF_TXDATA  = 3'd0,
    OFF_RXDATA  = 3'd1,
    OFF_STATUS  = 3'd2,
    OFF_IRQEN   = 3'd3,
    OFF_IRQSTAT = 3'd4,
    OFF_RXTHR   = 3'd5
  } off_e;

  localparam int IRQ_W       = 4;
  localparam int IRQ_RXTH    = 0;
  localparam int IRQ_TXEMPTY = 1;
  localparam int IRQ_TXOVF   = 2;
  localparam int IRQ_RXUDF   = 3;

  localparam int ST_TX_LSB = 0;
  localparam int ST_RX_LSB = 8;
  localparam int ST_FW     = 8;

  function automatic logic [31:0] status_word(input logic [ST_FW-1:0] tx, input logic [ST_FW-1:0] rx);
    logic [31:0] w;
    w = '0;
    w[ST_TX_LSB +: ST_FW] = tx;
    w[ST_RX_LSB +: ST_FW] = rx;
    return w;
  endfunction
endpackage

// File: rtl/fpio_mchan_fifo.sv
// Synchronous FIFO; push when full and pop when empty are silently refused.
module fpio_mchan_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(2**AW));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end
endmodule

// File: rtl/fpio_mchan.sv
// Multi-channel host-mapped stream bridge: per channel a TX and an RX FIFO plus IRQ registers.
module fpio_mchan
  import fpio_mchan_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_BITS    = 4,
  localparam int CHB = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [CHB+2:0]                     host_addr,
  input  logic                               host_write_en,
  input  logic                               host_read_en,
  input  logic [31:0]                        host_write_data,
  output logic [31:0]                        host_read_data,
  output logic [NUM_CHANNELS-1:0]            tx_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_data,
  input  logic [NUM_CHANNELS-1:0]            tx_ready,
  input  logic [NUM_CHANNELS-1:0]            rx_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_data,
  output logic [NUM_CHANNELS-1:0]            rx_ready,
  output logic                               irq
);
  localparam int CW = FIFO_BITS + 1;

  logic [CHB-1:0] w_ch;
  off_e           w_off;
  logic           w_chok;
  logic [31:0]    w_rdata;
  logic           w_unused;

  logic [NUM_CHANNELS-1:0][CW-1:0]         w_txcnt, w_rxcnt;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] w_rxhead;
  logic [NUM_CHANNELS-1:0]                 w_txfull, w_txempty, w_rxfull, w_rxempty;
  logic [NUM_CHANNELS-1:0][IRQ_W-1:0]      r_en, r_stat;
  logic [NUM_CHANNELS-1:0][CW-1:0]         r_thr;

  assign w_ch     = host_addr[CHB+2:3];
  assign w_off    = off_e'(host_addr[2:0]);
  assign w_chok   = ({1'b0, w_ch} < (CHB+1)'(NUM_CHANNELS));
  assign w_unused = &{1'b0, host_write_data};

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic             w_sel, w_txpush, w_rxpop, w_wr;
    logic [IRQ_W-1:0] w_set, w_clr;

    assign w_sel    = w_chok && (w_ch == CHB'(c));
    assign w_wr     = host_write_en && w_sel;
    assign w_txpush = w_wr && (w_off == OFF_TXDATA);
    assign w_rxpop  = host_read_en && w_sel && (w_off == OFF_RXDATA);

    fpio_mchan_fifo #(.DW(DATA_WIDTH), .AW(FIFO_BITS)) u_tx (
      .clk(clk), .rstn(rstn),
      .i_push(w_txpush), .i_pop(tx_valid[c] && tx_ready[c]),
      .i_wdata(host_write_data[DATA_WIDTH-1:0]),
      .o_rdata(tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_count(w_txcnt[c]), .o_full(w_txfull[c]), .o_empty(w_txempty[c])
    );

    fpio_mchan_fifo #(.DW(DATA_WIDTH), .AW(FIFO_BITS)) u_rx (
      .clk(clk), .rstn(rstn),
      .i_push(rx_valid[c]), .i_pop(w_rxpop),
      .i_wdata(rx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_rdata(w_rxhead[c]),
      .o_count(w_rxcnt[c]), .o_full(w_rxfull[c]), .o_empty(w_rxempty[c])
    );

    assign tx_valid[c] = !w_txempty[c];
    assign rx_ready[c] = !w_rxfull[c];

    always_comb begin
      w_set              = '0;
      w_set[IRQ_RXTH]    = (r_thr[c] != '0) && (w_rxcnt[c] >= r_thr[c]);
      w_set[IRQ_TXEMPTY] = w_txempty[c];
      w_set[IRQ_TXOVF]   = w_txpush && w_txfull[c];
      w_set[IRQ_RXUDF]   = w_rxpop && w_rxempty[c];
      w_clr = (w_wr && (w_off == OFF_IRQSTAT)) ? host_write_data[IRQ_W-1:0] : '0;
    end

    // Clear first, then OR in this cycle's causes so a fresh event is never lost.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_en[c]   <= '0;
        r_stat[c] <= '0;
        r_thr[c]  <= '0;
      end else begin
        r_stat[c] <= (r_stat[c] & ~w_clr) | w_set;
        if (w_wr && (w_off == OFF_IRQEN)) r_en[c]  <= host_write_data[IRQ_W-1:0];
        if (w_wr && (w_off == OFF_RXTHR)) r_thr[c] <= host_write_data[CW-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_chok) begin
      case (w_off)
        OFF_RXDATA:  w_rdata = w_rxempty[w_ch] ? '0 : 32'(w_rxhead[w_ch]);
        OFF_STATUS:  w_rdata = status_word(ST_FW'(w_txcnt[w_ch]), ST_FW'(w_rxcnt[w_ch]));
        OFF_IRQEN:   w_rdata = 32'(r_en[w_ch]);
        OFF_IRQSTAT: w_rdata = 32'(r_stat[w_ch]);
        OFF_RXTHR:   w_rdata = 32'(r_thr[w_ch]);
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      host_read_data <= '0;
      irq            <= 1'b0;
    end else begin
      if (host_read_en) host_read_data <= w_rdata;
      irq <= |(r_stat & r_en);
    end
  end
endmodule

// File: tb/tb_fpio_mchan.sv
// Scoreboard bench for fpio_mchan: queue-based channel model checked every cycle on the falling edge.
module tb_fpio_mchan;
  localparam int NCH = 4, DW = 8, FB = 4, CHB = 2, DEPTH = 16;
  typedef bit [DW-1:0] dat_t;

  logic clk = 0, rstn = 0;
  logic [CHB+2:0] host_addr = '0;
  logic host_write_en = 0, host_read_en = 0;
  logic [31:0] host_write_data = '0, host_read_data;
  logic [NCH-1:0] tx_valid, tx_ready = '0, rx_valid = '0, rx_ready;
  logic [NCH*DW-1:0] tx_data, rx_data = '0;
  logic irq;

  // second instance: 5 channels so an out-of-range channel number is addressable
  logic [5:0] h5_addr = '0;
  logic h5_we = 0, h5_re = 0;
  logic [31:0] h5_wd = '0, h5_rd;
  logic [4:0] tx5_valid, rx5_ready;
  logic [39:0] tx5_data;
  logic irq5;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fpio_mchan #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .FIFO_BITS(FB)) u_dut (
    .clk(clk), .rstn(rstn), .host_addr(host_addr), .host_write_en(host_write_en),
    .host_read_en(host_read_en), .host_write_data(host_write_data), .host_read_data(host_read_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq));

  fpio_mchan #(.NUM_CHANNELS(5), .DATA_WIDTH(8), .FIFO_BITS(4)) u_dut5 (
    .clk(clk), .rstn(rstn), .host_addr(h5_addr), .host_write_en(h5_we),
    .host_read_en(h5_re), .host_write_data(h5_wd), .host_read_data(h5_rd),
    .tx_valid(tx5_valid), .tx_data(tx5_data), .tx_ready(5'b0),
    .rx_valid(5'b0), .rx_data(40'b0), .rx_ready(rx5_ready), .irq(irq5));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  dat_t     txq [NCH][$];
  dat_t     rxq [NCH][$];
  bit [3:0] m_en [NCH], m_stat [NCH];
  bit [4:0] m_thr [NCH];
  bit       m_irq;
  logic [31:0] rdq [$];
  bit started = 0;

  task automatic model_step();
    int ch, off;
    bit chok, nirq;
    logic [31:0] exp;
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        txq[c].delete(); rxq[c].delete();
        m_en[c] = 0; m_stat[c] = 0; m_thr[c] = 0;
      end
      m_irq = 0;
      rdq.delete();
      rdq.push_back(32'h0);
      return;
    end
    nirq = 0;
    for (int c = 0; c < NCH; c++) if ((m_stat[c] & m_en[c]) != 0) nirq = 1;
    ch = int'(host_addr[CHB+2:3]);
    off = int'(host_addr[2:0]);
    chok = ch < NCH;
    if (host_read_en) begin
      exp = 0;
      if (chok) case (off)
        1: if (rxq[ch].size() > 0) exp = 32'(rxq[ch][0]);
        2: exp = {16'h0, 8'(rxq[ch].size()), 8'(txq[ch].size())};
        3: exp = 32'(m_en[ch]);
        4: exp = 32'(m_stat[ch]);
        5: exp = 32'(m_thr[ch]);
        default: exp = 0;
      endcase
      rdq.push_back(exp);
    end
    for (int c = 0; c < NCH; c++) begin
      bit [3:0] set, clr;
      bit wsel, rsel, txpush, rxpop, rxpush, txpop, txfull;
      wsel = host_write_en && chok && ch == c;
      rsel = host_read_en && chok && ch == c;
      txpush = wsel && off == 0;
      txfull = txq[c].size() == DEPTH;
      txpop = txq[c].size() > 0 && tx_ready[c];
      rxpop = rsel && off == 1 && rxq[c].size() > 0;
      rxpush = rx_valid[c] && rxq[c].size() < DEPTH;
      set = 0;
      if (m_thr[c] != 0 && rxq[c].size() >= int'(m_thr[c])) set[0] = 1;
      if (txq[c].size() == 0) set[1] = 1;
      if (txpush && txfull) set[2] = 1;
      if (rsel && off == 1 && rxq[c].size() == 0) set[3] = 1;
      clr = (wsel && off == 4) ? host_write_data[3:0] : 4'h0;
      m_stat[c] = (m_stat[c] & ~clr) | set;
      if (wsel && off == 3) m_en[c] = host_write_data[3:0];
      if (wsel && off == 5) m_thr[c] = host_write_data[4:0];
      if (txpop) void'(txq[c].pop_front());
      if (txpush && !txfull) txq[c].push_back(host_write_data[DW-1:0]);
      if (rxpop) void'(rxq[c].pop_front());
      if (rxpush) rxq[c].push_back(rx_data[c*DW +: DW]);
    end
    m_irq = nirq;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      if (rdq.size() > 0) check("read_data", host_read_data, rdq.pop_front());
      check("irq", 32'(irq), 32'(m_irq));
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("tx_valid%0d", c), 32'(tx_valid[c]), 32'(txq[c].size() != 0));
        check($sformatf("rx_ready%0d", c), 32'(rx_ready[c]), 32'(rxq[c].size() < DEPTH));
        if (tx_valid[c] && tx_ready[c] && txq[c].size() > 0)
          check($sformatf("tx_data%0d", c), 32'(tx_data[c*DW +: DW]), 32'(txq[c][0]));
      end
    end
    model_step();
    if (!rstn) started = 1;
  end

  // ---------------- stimulus ----------------
  task automatic host(input bit w, input bit r, input int ch, input int off, input logic [31:0] d);
    host_write_en = w; host_read_en = r;
    host_addr = {ch[CHB-1:0], off[2:0]};
    host_write_data = d;
    @(posedge clk); #1;
    host_write_en = 0; host_read_en = 0;
  endtask

  task automatic h5(input bit w, input bit r, input int ch, input int off, input logic [31:0] d);
    h5_we = w; h5_re = r;
    h5_addr = {ch[2:0], off[2:0]};
    h5_wd = d;
    @(posedge clk); #1;
    h5_we = 0; h5_re = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    rstn = 1;
    idle(1);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'hF);
    check("rst_rdata", host_read_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // ch0 single word through to the sink
    tx_ready[0] = 1;
    host(1, 0, 0, 0, 32'hA5);
    check("ch0_tx_valid", 32'(tx_valid[0]), 32'h1);
    check("ch0_tx_data", 32'(tx_data[7:0]), 32'hA5);
    idle(1);
    host(0, 1, 0, 2, 0);
    check("ch0_tx_count", host_read_data & 32'hFF, 32'h0);
    tx_ready[0] = 0;

    // ch1 overflow: 17th write dropped
    for (int i = 0; i < 17; i++) host(1, 0, 1, 0, 32'h10 + i);
    host(0, 1, 1, 2, 0);
    check("ch1_tx_count", host_read_data & 32'hFF, 32'd16);
    host(0, 1, 1, 4, 0);
    check("ch1_ovf", (host_read_data >> 2) & 1, 32'h1);
    tx_ready[1] = 1;
    idle(20);
    tx_ready[1] = 0;
    check("ch1_drained", 32'(tx_valid[1]), 32'h0);

    // ch2 rx threshold interrupt
    host(1, 0, 2, 5, 3);
    host(1, 0, 2, 3, 1);
    host(1, 0, 2, 4, 32'hF);
    rx_valid[2] = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data[2*DW +: DW] = 8'h30 + 8'(i);
      idle(1);
    end
    rx_valid[2] = 0;
    idle(3);
    check("ch2_irq_set", 32'(irq), 32'h1);
    host(0, 1, 2, 1, 0);
    check("ch2_rx_head", host_read_data, 32'h30);
    host(1, 0, 2, 4, 1);
    idle(1);
    check("ch2_irq_clr", 32'(irq), 32'h0);

    // ch3 underflow
    host(0, 1, 3, 1, 0);
    check("ch3_udf_data", host_read_data, 32'h0);
    host(0, 1, 3, 4, 0);
    check("ch3_udf_flag", (host_read_data >> 3) & 1, 32'h1);
    host(0, 1, 3, 2, 0);
    check("ch3_rx_count", (host_read_data >> 8) & 32'hFF, 32'h0);

    // reset mid-fill
    for (int i = 0; i < 5; i++) host(1, 0, 0, 0, 32'h50 + i);
    rstn = 0;
    idle(1);
    rstn = 1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    host(0, 1, 0, 2, 0);
    check("mid_rst_status", host_read_data, 32'h0);

    // unmapped offsets
    host(1, 0, 0, 6, 32'hFFFF_FFFF);
    host(0, 1, 0, 6, 0);
    check("off6_read", host_read_data, 32'h0);
    host(0, 1, 1, 7, 0);
    check("off7_read", host_read_data, 32'h0);

    // out-of-range channel on the 5-channel instance
    h5(1, 0, 7, 3, 32'hF);
    h5(1, 0, 7, 0, 32'h77);
    h5(1, 0, 7, 5, 32'h4);
    h5(0, 1, 7, 3, 0);
    check("ch7_irqen", h5_rd, 32'h0);
    h5(0, 1, 4, 3, 0);
    check("ch4_irqen", h5_rd, 32'h0);
    h5(0, 1, 4, 5, 0);
    check("ch4_thr", h5_rd, 32'h0);
    check("dut5_tx_valid", 32'(tx5_valid), 32'h0);
    check("dut5_irq", 32'(irq5), 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rx_valid = 4'($urandom);
      tx_ready = 4'($urandom_range(0, 15) & (n[9] ? 4'hF : 4'h3));
      rx_data = 32'($urandom);
      host_write_en = ($urandom_range(0, 2) == 0);
      host_read_en = ($urandom_range(0, 2) == 0);
      host_addr = 5'($urandom);
      if ($urandom_range(0, 1) == 0) host_addr[2:0] = 3'($urandom_range(0, 1));
      host_write_data = $urandom;
      if (host_addr[2:0] == 3'd5) host_write_data = 32'($urandom_range(0, 17));
      rstn = ($urandom_range(0, 599) != 0);
      @(posedge clk); #1;
    end
    rstn = 1; host_write_en = 0; host_read_en = 0; rx_valid = 0; tx_ready = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
